// File: rtl/rv_ctl.sv
// rv_ctl: Moore control FSM sequencing the multicycle RV32I datapath.
// Optional macro RV_CTL_MEM_WAIT_EN adds imem_rdy/dmem_rdy handshakes that
// stall FETCH and the data-memory states until the memory is ready.
module rv_ctl #(
    parameter int DPWIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
`ifdef RV_CTL_MEM_WAIT_EN
    input  logic               imem_rdy,
    input  logic               dmem_rdy,
`endif
    input  logic [DPWIDTH-1:0] instr,
    input  logic               zero,
    output logic               pcsourse,
    output logic               pcwrite,
    output logic               pccen,
    output logic               irwrite,
    output logic [1:0]         wbsel,
    output logic               regwen,
    output logic [1:0]         immsel,
    output logic               asel,
    output logic               bsel,
    output logic [3:0]         alusel,
    output logic               mdrwrite,
    output logic               dmem_re,
    output logic               dmem_we,
    output logic               instr_done,
    output logic               halted
);

    localparam logic       PC_PLUS4 = 1'b0, PC_ALU = 1'b1;
    localparam logic [1:0] WB_MDR = 2'd0, WB_ALUOUT = 2'd1, WB_PC = 2'd2;
    localparam logic [1:0] IMM_J = 2'd0, IMM_B = 2'd1, IMM_S = 2'd2, IMM_L = 2'd3;
    localparam logic       ALUA_REG = 1'b0, ALUA_PCC = 1'b1;
    localparam logic       ALUB_REG = 1'b0, ALUB_IMM = 1'b1;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                           XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                           OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
        WB_ALU, BRANCH, JAL, JALR_EX, JALR_WB, HALT
    } state_t;

    state_t state, state_nxt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       imem_ok, dmem_ok;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign alt    = instr[30];
    // Register indices and immediates belong to the datapath; only opcode,
    // funct3 and bit 30 steer control.
    assign unused_instr_bits = ^{instr[DPWIDTH-1:31], instr[29:15], instr[11:7]};

`ifdef RV_CTL_MEM_WAIT_EN
    assign imem_ok = imem_rdy;
    assign dmem_ok = dmem_rdy;
`else
    assign imem_ok = 1'b1;
    assign dmem_ok = 1'b1;
`endif

    // funct3 to ALU op; alt picks SUB/SRA where funct3 shares an encoding
    function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic a);
        case (f3)
            3'b000:  return a ? SUB : ADD;
            3'b001:  return SLL;
            3'b010:  return SLT;
            3'b011:  return SLTU;
            3'b100:  return XOR;
            3'b101:  return a ? SRA : SRL;
            3'b110:  return OR;
            default: return AND;
        endcase
    endfunction

    // State register; reset returns to FETCH at once, abandoning any instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    // Next-state and Moore outputs (branch pcwrite also looks at zero)
    always_comb begin
        state_nxt  = state;
        pcsourse   = PC_PLUS4;
        pcwrite    = 1'b0;
        pccen      = 1'b0;
        irwrite    = 1'b0;
        wbsel      = WB_MDR;
        regwen     = 1'b0;
        immsel     = IMM_J;
        asel       = ALUA_REG;
        bsel       = ALUB_REG;
        alusel     = ADD;
        mdrwrite   = 1'b0;
        dmem_re    = 1'b0;
        dmem_we    = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ok) begin
                    irwrite   = 1'b1;
                    pccen     = 1'b1;
                    pcwrite   = 1'b1;
                    pcsourse  = PC_PLUS4;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                // Precompute the jump/branch target while A/B latch rs1/rs2
                asel   = ALUA_PCC;
                bsel   = ALUB_IMM;
                alusel = ADD;
                immsel = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_R:    state_nxt = EXEC_R;
                    OP_I:    state_nxt = (funct3 == 3'b101 && alt) ? HALT : EXEC_I;
                    OP_LD:   state_nxt = (funct3 == 3'b010) ? MEM_ADDR : HALT;
                    OP_ST:   state_nxt = (funct3 == 3'b010) ? MEM_ADDR : HALT;
                    OP_BR:   state_nxt = (funct3[2:1] == 2'b01) ? HALT : BRANCH;
                    OP_JAL:  state_nxt = JAL;
                    OP_JALR: state_nxt = JALR_EX;
                    default: state_nxt = HALT;
                endcase
            end
            EXEC_R: begin
                alusel    = alu_f3(funct3, alt);
                state_nxt = WB_ALU;
            end
            EXEC_I: begin
                bsel      = ALUB_IMM;
                immsel    = IMM_L;
                alusel    = alu_f3(funct3, (funct3 == 3'b101) && alt);
                state_nxt = WB_ALU;
            end
            WB_ALU: begin
                wbsel      = WB_ALUOUT;
                regwen     = 1'b1;
                instr_done = 1'b1;
                state_nxt  = FETCH;
            end
            MEM_ADDR: begin
                bsel      = ALUB_IMM;
                alusel    = ADD;
                // opcode bit 5 separates store from load
                immsel    = opcode[5] ? IMM_S : IMM_L;
                state_nxt = opcode[5] ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                dmem_re = 1'b1;
                if (dmem_ok) begin
                    mdrwrite  = 1'b1;
                    state_nxt = MEM_WB;
                end
            end
            MEM_WB: begin
                wbsel      = WB_MDR;
                regwen     = 1'b1;
                instr_done = 1'b1;
                state_nxt  = FETCH;
            end
            MEM_WR: begin
                dmem_we = 1'b1;
                if (dmem_ok) begin
                    instr_done = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            BRANCH: begin
                pcsourse   = PC_ALU;
                instr_done = 1'b1;
                alusel     = !funct3[2] ? SUB : (funct3[1] ? SLTU : SLT);
                // BEQ/BGE/BGEU take on zero; BNE/BLT/BLTU take on !zero
                pcwrite    = zero ^ (funct3[2] ^ funct3[0]);
                state_nxt  = FETCH;
            end
            JAL, JALR_WB: begin
                wbsel      = WB_PC;
                regwen     = 1'b1;
                pcwrite    = 1'b1;
                pcsourse   = PC_ALU;
                instr_done = 1'b1;
                state_nxt  = FETCH;
            end
            JALR_EX: begin
                bsel      = ALUB_IMM;
                immsel    = IMM_L;
                alusel    = ADD;
                state_nxt = JALR_WB;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = HALT;
        endcase
    end

endmodule

// File: tb/tb_rv_ctl.sv
// tb_rv_ctl: scoreboard bench for rv_ctl. Stimulus pushes the expected
// per-cycle output word from an instruction-level reference model; a monitor
// on the falling edge pops and compares against the DUT.
module tb_rv_ctl;

    typedef struct packed {
        logic       pcsourse, pcwrite, pccen, irwrite;
        logic [1:0] wbsel;
        logic       regwen;
        logic [1:0] immsel;
        logic       asel, bsel;
        logic [3:0] alusel;
        logic       mdrwrite, dmem_re, dmem_we, instr_done, halted;
    } ov_t;

    typedef enum int { K_R, K_I, K_LW, K_SW, K_BR, K_JAL, K_JALR, K_ILL } kind_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    ov_t         act;

    rv_ctl #(.DPWIDTH(32)) dut (
        .clk(clk), .rst(rst),
`ifdef RV_CTL_MEM_WAIT_EN
        .imem_rdy(1'b1), .dmem_rdy(1'b1),
`endif
        .instr(instr), .zero(zero),
        .pcsourse(act.pcsourse), .pcwrite(act.pcwrite), .pccen(act.pccen),
        .irwrite(act.irwrite), .wbsel(act.wbsel), .regwen(act.regwen),
        .immsel(act.immsel), .asel(act.asel), .bsel(act.bsel),
        .alusel(act.alusel), .mdrwrite(act.mdrwrite), .dmem_re(act.dmem_re),
        .dmem_we(act.dmem_we), .instr_done(act.instr_done), .halted(act.halted)
    );

    always #5 clk = ~clk;

    ov_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    // ---------------- reference model ----------------
    function automatic kind_t kind_of(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'b0110011: return K_R;
            7'b0010011: return (f3 == 3'd5 && ins[30]) ? K_ILL : K_I;
            7'b0000011: return (f3 == 3'd2) ? K_LW : K_ILL;
            7'b0100011: return (f3 == 3'd2) ? K_SW : K_ILL;
            7'b1100011: return (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            default:    return K_ILL;
        endcase
    endfunction

    // Cycles from FETCH to retire; illegal ops: fetch, decode, then 20 halted cycles
    function automatic int n_cycles(input logic [31:0] ins);
        case (kind_of(ins))
            K_LW:         return 5;
            K_BR, K_JAL:  return 3;
            K_ILL:        return 22;
            default:      return 4;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [3:0] tbl [8];
        tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        return tbl[f3] + ((f3 == 3'd0 || f3 == 3'd5) && alt ? 4'd1 : 4'd0);
    endfunction

    function automatic ov_t fetch_vec();
        ov_t o = '0;
        o.irwrite = 1; o.pccen = 1; o.pcwrite = 1;
        return o;
    endfunction

    function automatic ov_t link_vec();
        ov_t o = '0;
        o.wbsel = 2; o.regwen = 1; o.pcwrite = 1; o.pcsourse = 1; o.instr_done = 1;
        return o;
    endfunction

    function automatic ov_t model(input logic [31:0] ins, input int k, input logic z);
        ov_t        o = '0;
        kind_t      kd = kind_of(ins);
        logic [2:0] f3 = ins[14:12];
        if (k == 0) return fetch_vec();
        if (k == 1) begin
            o.asel = 1; o.bsel = 1;
            o.immsel = (ins[6:0] == 7'b1101111) ? 2'd0 : 2'd1;
            return o;
        end
        case (kd)
            K_R: if (k == 2) o.alusel = alu_of(f3, ins[30]);
                 else begin o.wbsel = 1; o.regwen = 1; o.instr_done = 1; end
            K_I: if (k == 2) begin o.bsel = 1; o.immsel = 3; o.alusel = alu_of(f3, 1'b0); end
                 else begin o.wbsel = 1; o.regwen = 1; o.instr_done = 1; end
            K_LW: case (k)
                2: begin o.bsel = 1; o.immsel = 3; end
                3: begin o.dmem_re = 1; o.mdrwrite = 1; end
                default: begin o.wbsel = 0; o.regwen = 1; o.instr_done = 1; end
            endcase
            K_SW: if (k == 2) begin o.bsel = 1; o.immsel = 2; end
                  else begin o.dmem_we = 1; o.instr_done = 1; end
            K_BR: begin
                o.pcsourse = 1; o.instr_done = 1;
                case (f3)
                    3'd0, 3'd1: o.alusel = 4'd1;
                    3'd4, 3'd5: o.alusel = 4'd3;
                    default:    o.alusel = 4'd4;
                endcase
                // equal / greater-or-equal forms are taken when the ALU result is zero
                o.pcwrite = (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7) ? z : !z;
            end
            K_JAL: o = link_vec();
            K_JALR: if (k == 2) begin o.bsel = 1; o.immsel = 3; end
                    else o = link_vec();
            default: o.halted = 1;
        endcase
        return o;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ov_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t instr=%h zero=%b got=%h want=%h",
                         $time, instr, zero, act, e);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        rst = 1'b1;
        exp_q.push_back(fetch_vec());  // reset forces FETCH, halted clear
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // zm: 0/1 force zero, 2 random; cut>0 aborts by reset after cut cycles
    task automatic run_instr(input logic [31:0] ins, input int zm, input int cut);
        int n;
        n = n_cycles(ins);
        if (cut > 0 && cut < n) n = cut;
        instr = ins;
        for (int k = 0; k < n; k++) begin
            zero = (zm == 2) ? 1'($urandom) : 1'(zm);
            exp_q.push_back(model(ins, k, zero));
            @(posedge clk); #1;
        end
        if (kind_of(ins) == K_ILL || (cut > 0 && cut < n_cycles(ins))) do_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 9))
            0, 9: r[6:0] = 7'b0110011;
            1: begin r[6:0] = 7'b0010011; if ($urandom_range(0, 3) != 0) r[30] = 1'b0; end
            2: begin r[6:0] = 7'b0000011; if ($urandom_range(0, 4) != 0) r[14:12] = 3'd2; end
            3: begin r[6:0] = 7'b0100011; if ($urandom_range(0, 4) != 0) r[14:12] = 3'd2; end
            4, 5: r[6:0] = 7'b1100011;
            6: r[6:0] = 7'b1101111;
            7: r[6:0] = 7'b1100111;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        @(posedge clk); #1;
        do_reset();
        // directed cases
        run_instr(32'h002081B3, 2, 0);  // ADD x3,x1,x2
        run_instr(32'h00802283, 2, 0);  // LW x5,8(x0)
        run_instr(32'h00000463, 1, 0);  // BEQ taken
        run_instr(32'h00000463, 0, 0);  // BEQ not taken
        run_instr(32'h010000EF, 2, 0);  // JAL x1,+16
        run_instr(32'h0020A223, 2, 0);  // SW x2,4(x1)
        run_instr(32'h000080E7, 2, 0);  // JALR x1,0(x1)
        run_instr(32'h40515093, 2, 0);  // SRAI -> halt
        run_instr(32'h000010B7, 2, 0);  // LUI -> halt
        run_instr(32'h402081B3, 2, 2);  // SUB, reset after decode
        // randomized
        for (int i = 0; i < 300; i++)
            run_instr(rand_instr(), 2, ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0);
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
